// File: rtl/mod_counter.sv
// Parametrised up/down counter with modulus, prescaled enable, clear/load,
// wrap or saturate at the bounds, and terminal-count / bound flags.
module mod_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_VAL    = 2**WIDTH-1,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0]      out_q, out_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tc_q, tc_d;
    logic                  tick;

    always_comb begin
        out_d  = out_q;
        pcnt_d = pcnt_q;
        tc_d   = 1'b0;
        tick   = 1'b0;
        if (clr) begin
            out_d  = '0;
            pcnt_d = '0;
        end else if (load) begin
            out_d  = (load_val > MAX_V) ? MAX_V : load_val;
            pcnt_d = '0;
        end else if (en) begin
            // ">=" so that lowering prescale below the running phase ticks at once
            tick   = (pcnt_q >= prescale);
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                if (up) begin
                    if (out_q < MAX_V) begin
                        out_d = out_q + 1'b1;
                        tc_d  = sat && (out_d == MAX_V);
                    end else if (!sat) begin
                        out_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    if (out_q != '0) begin
                        out_d = out_q - 1'b1;
                        tc_d  = sat && (out_d == '0);
                    end else if (!sat) begin
                        out_d = MAX_V;
                        tc_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= '0;
            pcnt_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            pcnt_q <= pcnt_d;
            tc_q   <= tc_d;
        end
    end

    assign out    = out_q;
    assign tc     = tc_q;
    assign at_max = (out_q == MAX_V);
    assign at_min = (out_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (full-range and modulus-10) share one
// stimulus stream and are checked every cycle against an integer model.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] prescale = '0;

    logic [7:0] out0, out1;
    logic       tc0, tc1, at_max0, at_max1, at_min0, at_min1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .PRESCALE_W(4)) u0 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat), .prescale(prescale),
        .out(out0), .tc(tc0), .at_max(at_max0), .at_min(at_min0)
    );

    mod_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat), .prescale(prescale),
        .out(out1), .tc(tc1), .at_max(at_max1), .at_min(at_min1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count value and prescale phase as plain integers.
    int m_out [2] = '{0, 0};
    int m_pcnt[2] = '{0, 0};
    int m_tc  [2] = '{0, 0};
    int maxv  [2] = '{255, 9};

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_out[k] = 0; m_pcnt[k] = 0; m_tc[k] = 0;
            end else if (clr) begin
                m_out[k] = 0; m_pcnt[k] = 0; m_tc[k] = 0;
            end else if (load) begin
                m_out[k]  = (int'(load_val) > maxv[k]) ? maxv[k] : int'(load_val);
                m_pcnt[k] = 0; m_tc[k] = 0;
            end else begin
                m_tc[k] = 0;
                if (en) begin
                    if (m_pcnt[k] >= int'(prescale)) begin
                        m_pcnt[k] = 0;
                        if (up) begin
                            if (m_out[k] < maxv[k]) begin
                                m_out[k]++;
                                m_tc[k] = (sat && m_out[k] == maxv[k]) ? 1 : 0;
                            end else if (!sat) begin
                                m_out[k] = 0; m_tc[k] = 1;
                            end
                        end else begin
                            if (m_out[k] > 0) begin
                                m_out[k]--;
                                m_tc[k] = (sat && m_out[k] == 0) ? 1 : 0;
                            end else if (!sat) begin
                                m_out[k] = maxv[k]; m_tc[k] = 1;
                            end
                        end
                    end else begin
                        m_pcnt[k]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("u0.out",    int'(out0),    m_out[0]);
            check("u0.tc",     int'(tc0),     m_tc[0]);
            check("u0.at_max", int'(at_max0), (m_out[0] == maxv[0]) ? 1 : 0);
            check("u0.at_min", int'(at_min0), (m_out[0] == 0) ? 1 : 0);
            check("u1.out",    int'(out1),    m_out[1]);
            check("u1.tc",     int'(tc1),     m_tc[1]);
            check("u1.at_max", int'(at_max1), (m_out[1] == maxv[1]) ? 1 : 0);
            check("u1.at_min", int'(at_min1), (m_out[1] == 0) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        #2;
        check("rst.out",    int'(out0),    0);
        check("rst.tc",     int'(tc0),     0);
        check("rst.at_min", int'(at_min0), 1);
        check("rst.at_max", int'(at_max0), 0);
        cyc(2);
        reset_n = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0; prescale = 4'd0;

        // Full-range count and natural wrap.
        cyc(1);   check("cnt.first", int'(out0), 1);
                  check("cnt.min_off", int'(at_min0), 0);
        cyc(3);   check("cnt.four", int'(out0), 4);
        cyc(251); check("cnt.255", int'(out0), 255);
                  check("cnt.at_max", int'(at_max0), 1);
        cyc(1);   check("wrap.out", int'(out0), 0);
                  check("wrap.tc", int'(tc0), 1);
                  check("wrap.at_min", int'(at_min0), 1);
        cyc(1);   check("wrap.out1", int'(out0), 1);
                  check("wrap.tc_drop", int'(tc0), 0);

        // Modulus 10 with prescale 2, enable freeze mid-phase.
        clr = 1'b1;
        cyc(1);   check("clr.out", int'(out1), 0);
        clr = 1'b0; prescale = 4'd2;
        cyc(2);   check("ps.hold", int'(out1), 0);
        cyc(1);   check("ps.step", int'(out1), 1);
        cyc(3);   check("ps.step2", int'(out1), 2);
        cyc(1);
        en = 1'b0;
        cyc(5);   check("freeze.out", int'(out1), 2);
        en = 1'b1;
        cyc(1);   check("freeze.phase", int'(out1), 2);
        cyc(1);   check("freeze.resume", int'(out1), 3);
        cyc(18);  check("mod.nine", int'(out1), 9);
        cyc(3);   check("mod.wrap", int'(out1), 0);
                  check("mod.tc", int'(tc1), 1);
        cyc(1);   check("mod.tc_drop", int'(tc1), 0);

        // Clamped load, then saturating count down.
        load_val = 8'd20; load = 1'b1;
        cyc(1);   check("clamp.out", int'(out1), 9);
                  check("clamp.at_max", int'(at_max1), 1);
                  check("noclamp.out", int'(out0), 20);
        load = 1'b0; up = 1'b0; sat = 1'b1; prescale = 4'd0;
        cyc(8);   check("down.one", int'(out1), 1);
        cyc(1);   check("down.zero", int'(out1), 0);
                  check("down.tc", int'(tc1), 1);
        cyc(1);   check("pin.out", int'(out1), 0);
                  check("pin.tc", int'(tc1), 0);
        cyc(2);   check("pin.tc2", int'(tc1), 0);

        // clr beats load; load restarts the prescale phase.
        load_val = 8'd5; load = 1'b1;
        cyc(1);   check("ld5", int'(out1), 5);
        clr = 1'b1;
        cyc(1);   check("clrld.out", int'(out1), 0);
                  check("clrld.tc", int'(tc1), 0);
        clr = 1'b0; load_val = 8'd3; up = 1'b1; prescale = 4'd2;
        cyc(1);   check("ld3", int'(out1), 3);
        load = 1'b0;
        cyc(2);   check("ld3.hold", int'(out1), 3);
        cyc(1);   check("ld3.step", int'(out1), 4);

        // Asynchronous reset between edges mid-prescale.
        load_val = 8'd7; load = 1'b1;
        cyc(1);
        load = 1'b0; prescale = 4'd3;
        cyc(2);   check("pre_rst.out", int'(out1), 7);
        #2 reset_n = 1'b0;
        #1;       check("async.out", int'(out1), 0);
                  check("async.at_min", int'(at_min1), 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(3);   check("rel.hold", int'(out1), 0);
        cyc(1);   check("rel.step", int'(out1), 1);

        // Direction flip across the bounds in wrap mode.
        up = 1'b0; sat = 1'b0; prescale = 4'd0; load_val = 8'd0; load = 1'b1;
        cyc(1);   check("flip.ld0", int'(out1), 0);
        load = 1'b0;
        cyc(1);   check("flip.down", int'(out1), 9);
                  check("flip.down_tc", int'(tc1), 1);
        up = 1'b1;
        cyc(1);   check("flip.up", int'(out1), 0);
                  check("flip.up_tc", int'(tc1), 1);

        // Randomised phase; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 8'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) up = ~up;
            if ($urandom_range(0, 39) == 0) sat = ~sat;
            if ($urandom_range(0, 7) == 0)
                prescale = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0)
                prescale = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
